// File: rtl/address_range_generator.sv
// address_range_generator: emits the address sequence ADDR_BASE, ADDR_BASE+stride, ...
// up to ADDR_BOUND over a valid/ready handshake. The sequence either makes a single pass
// or wraps back to ADDR_BASE continuously.
// Optional feature: define ADDR_RANGE_GENERATOR_PASS_COUNT_EN to add the pass_count output.
// pass_count counts overflow transfers and saturates at all-ones.
module address_range_generator #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ADDR_BASE  = 0,
    parameter int unsigned ADDR_BOUND = 255
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  wrap,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic                  last,
    output logic                  busy,
    output logic                  done
`ifdef ADDR_RANGE_GENERATOR_PASS_COUNT_EN
    ,
    output logic [ADDR_WIDTH-1:0] pass_count
`endif
);

    // The range must be non-empty and representable in ADDR_WIDTH bits.
    if (ADDR_WIDTH < 1) begin : g_bad_width
        $error("address_range_generator: ADDR_WIDTH must be at least 1");
    end
    if ((ADDR_BOUND < ADDR_BASE) ||
        (longint'(ADDR_BOUND) >= (longint'(1) << ADDR_WIDTH))) begin : g_bad_range
        $error("address_range_generator: need ADDR_BASE <= ADDR_BOUND < 2**ADDR_WIDTH");
    end

    localparam int unsigned SUM_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BASE_VAL  = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [SUM_W-1:0]      BOUND_EXT = SUM_W'(ADDR_BOUND);
    localparam logic [ADDR_WIDTH-1:0] ONE_VAL   = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_t;

    state_t                  state;
    logic                    wrap_q;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [SUM_W-1:0]        sum;
    logic                    overflow;
    logic                    transfer;
    logic                    accept_start;

    // Next-address arithmetic is one bit wider so a carry out counts as overflow.
    always_comb begin
        sum          = {1'b0, addr} + {1'b0, stride_q};
        overflow     = (sum > BOUND_EXT);
        transfer     = addr_valid && addr_ready;
        accept_start = (state == StIdle) && start && !stop;
        last         = addr_valid && !wrap_q && overflow;
        busy         = (state != StIdle);
    end

    // Sequencer: latches the configuration at start and walks the range per transfer.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= StIdle;
            addr       <= BASE_VAL;
            addr_valid <= 1'b0;
            done       <= 1'b0;
            wrap_q     <= 1'b0;
            stride_q   <= ONE_VAL;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept_start) begin
                        state      <= StRun;
                        addr       <= BASE_VAL;
                        addr_valid <= 1'b1;
                        wrap_q     <= wrap;
                        // A zero stride would never advance; treat it as 1.
                        stride_q   <= (stride == '0) ? ONE_VAL : stride;
                    end
                end
                StRun: begin
                    if (stop) begin
                        // Abort: a concurrent transfer still happened, but addr is held
                        // and no completion is signalled.
                        state      <= StIdle;
                        addr_valid <= 1'b0;
                    end else if (transfer) begin
                        if (!overflow) begin
                            addr <= sum[ADDR_WIDTH-1:0];
                        end else if (wrap_q) begin
                            addr <= BASE_VAL;
                        end else begin
                            state      <= StIdle;
                            addr_valid <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= StIdle;
                    addr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADDR_RANGE_GENERATOR_PASS_COUNT_EN
    // Pass counter: cleared on each accepted start, bumped per overflow transfer, saturating.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pass_count <= '0;
        end else if (accept_start) begin
            pass_count <= '0;
        end else if (transfer && overflow && (pass_count != '1)) begin
            pass_count <= pass_count + ONE_VAL;
        end
    end
`endif

endmodule

// File: tb/tb_address_range_generator.sv
// Self-checking bench for address_range_generator: directed scenarios and randomized traffic.
// Main instance (BASE=4, BOUND=9) is compared every cycle against an arithmetic model.
// Two extra instances cover the single-address range and carry-out boundaries.
module tb_address_range_generator;

    localparam int BASE_A  = 4;
    localparam int BOUND_A = 9;

    logic       clock;
    logic       clear_n;
    logic       start;
    logic       stop;
    logic       wrap;
    logic [7:0] stride_a;
    logic [7:0] stride_b;
    logic [7:0] stride_c;
    logic       addr_ready;

    logic [7:0] addr_a, addr_b, addr_c;
    logic       valid_a, valid_b, valid_c;
    logic       last_a, last_b, last_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
`ifdef ADDR_RANGE_GENERATOR_PASS_COUNT_EN
    logic [7:0] pc_a, pc_b, pc_c;
`endif

    address_range_generator #(.ADDR_WIDTH(8), .ADDR_BASE(BASE_A), .ADDR_BOUND(BOUND_A)) dut_a (
        .clock(clock), .clear_n(clear_n), .start(start), .stop(stop), .wrap(wrap),
        .stride(stride_a), .addr(addr_a), .addr_valid(valid_a), .addr_ready(addr_ready),
        .last(last_a), .busy(busy_a), .done(done_a)
`ifdef ADDR_RANGE_GENERATOR_PASS_COUNT_EN
        , .pass_count(pc_a)
`endif
    );

    address_range_generator #(.ADDR_WIDTH(8), .ADDR_BASE(200), .ADDR_BOUND(200)) dut_b (
        .clock(clock), .clear_n(clear_n), .start(start), .stop(stop), .wrap(wrap),
        .stride(stride_b), .addr(addr_b), .addr_valid(valid_b), .addr_ready(addr_ready),
        .last(last_b), .busy(busy_b), .done(done_b)
`ifdef ADDR_RANGE_GENERATOR_PASS_COUNT_EN
        , .pass_count(pc_b)
`endif
    );

    address_range_generator #(.ADDR_WIDTH(8), .ADDR_BASE(250), .ADDR_BOUND(255)) dut_c (
        .clock(clock), .clear_n(clear_n), .start(start), .stop(stop), .wrap(wrap),
        .stride(stride_c), .addr(addr_c), .addr_valid(valid_c), .addr_ready(addr_ready),
        .last(last_c), .busy(busy_c), .done(done_c)
`ifdef ADDR_RANGE_GENERATOR_PASS_COUNT_EN
        , .pass_count(pc_c)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for dut_a, in plain integers.
    bit m_run  = 0;
    bit m_done = 0;
    bit m_wrap = 0;
    int m_addr = BASE_A;
    int m_stride = 1;
    int m_pc = 0;
    int xq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: compare dut_a with the model, drive inputs, then advance the model.
    task automatic cycle(input bit s, input bit p, input bit w, input logic [7:0] st,
                         input bit r);
        bit exp_last;
        bit ovf;
        @(negedge clock);
        exp_last = m_run && !m_wrap && (m_addr + m_stride > BOUND_A);
        check("addr_valid", 32'(valid_a), 32'(m_run));
        check("busy", 32'(busy_a), 32'(m_run));
        check("done", 32'(done_a), 32'(m_done));
        check("last", 32'(last_a), 32'(exp_last));
        if (m_run) check("addr", 32'(addr_a), 32'(m_addr));
`ifdef ADDR_RANGE_GENERATOR_PASS_COUNT_EN
        check("pass_count", 32'(pc_a), 32'(m_pc));
`endif
        if (valid_a && r) xq.push_back(int'(addr_a));
        start = s; stop = p; wrap = w; stride_a = st; addr_ready = r;
        @(posedge clock);
        m_done = 0;
        if (!m_run) begin
            if (s && !p) begin
                m_run = 1; m_addr = BASE_A; m_wrap = w;
                m_stride = (st == 0) ? 1 : int'(st);
                m_pc = 0;
            end
        end else begin
            ovf = (m_addr + m_stride > BOUND_A);
            if (r && ovf && m_pc < 255) m_pc++;
            if (p) m_run = 0;
            else if (r) begin
                if (!ovf) m_addr = m_addr + m_stride;
                else if (m_wrap) m_addr = BASE_A;
                else begin m_run = 0; m_done = 1; end
            end
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic rst_pulse();
        @(negedge clock);
        start = 0; stop = 0; addr_ready = 0;
        #2 clear_n = 1'b0;
        #1;
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'(BASE_A));
        #1 clear_n = 1'b1;
        m_run = 0; m_done = 0; m_pc = 0;
    endtask

    initial begin
        logic [7:0] st;
        clear_n = 0; start = 0; stop = 0; wrap = 0; addr_ready = 0;
        stride_a = 0; stride_b = 0; stride_c = 0;
        #12;
        check("reset_addr_a", 32'(addr_a), 32'd4);
        check("reset_addr_b", 32'(addr_b), 32'd200);
        check("reset_addr_c", 32'(addr_c), 32'd250);
        check("reset_valid", 32'(valid_a), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_last", 32'(last_a), 32'd0);
        clear_n = 1;

        // Single pass, stride 2: 4, 6, 8 then done.
        xq.delete();
        cycle(1, 0, 0, 8'd2, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'd0, 1);
        check("pass_len", 32'(xq.size()), 32'd3);
        if (xq.size() == 3) begin
            check("pass_0", 32'(xq[0]), 32'd4);
            check("pass_1", 32'(xq[1]), 32'd6);
            check("pass_2", 32'(xq[2]), 32'd8);
        end

        // Wrap mode: 4, 6, 8, 4, 6, 8, 4, 6.
        xq.delete();
        cycle(1, 0, 1, 8'd2, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 8'd0, 1);
        cycle(0, 1, 0, 8'd0, 0);
        check("wrap_len", 32'(xq.size()), 32'd8);
        if (xq.size() == 8) begin
            check("wrap_3", 32'(xq[3]), 32'd4);
            check("wrap_5", 32'(xq[5]), 32'd8);
        end

        // Backpressure at addr=6 for 5 cycles, then resume.
        cycle(1, 0, 0, 8'd2, 1);
        cycle(0, 0, 0, 8'd0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'd0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'd0, 1);

        // Stop during the transfer of 6; then start+stop together in idle.
        cycle(1, 0, 0, 8'd2, 1);
        cycle(0, 0, 0, 8'd0, 1);
        cycle(0, 1, 0, 8'd0, 1);
        cycle(1, 1, 0, 8'd2, 1);
        cycle(0, 0, 0, 8'd0, 1);

        // Reset mid-run, then restart at BASE.
        cycle(1, 0, 1, 8'd1, 1);
        cycle(0, 0, 0, 8'd0, 1);
        rst_pulse();
        cycle(1, 0, 0, 8'd3, 0);
        cycle(0, 0, 0, 8'd0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'd0, 1);

        // Randomized traffic with occasional resets and large strides (carry-out cases).
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 149) == 0) rst_pulse();
            st = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, st, $urandom_range(0, 3) != 0);
        end

        // Boundary instances: BASE=BOUND=200 with stride 0, and 250..255 with stride 10.
        rst_pulse();
        stride_b = 8'd0;
        stride_c = 8'd10;
        cycle(1, 0, 0, 8'd1, 0);
        #1;
        check("b_valid", 32'(valid_b), 32'd1);
        check("b_addr", 32'(addr_b), 32'd200);
        check("b_last", 32'(last_b), 32'd1);
        check("c_valid", 32'(valid_c), 32'd1);
        check("c_addr", 32'(addr_c), 32'd250);
        check("c_last", 32'(last_c), 32'd1);
        cycle(0, 0, 0, 8'd1, 1);
        #1;
        check("b_done", 32'(done_b), 32'd1);
        check("b_busy", 32'(busy_b), 32'd0);
        check("c_done", 32'(done_c), 32'd1);
        check("c_valid_end", 32'(valid_c), 32'd0);
        cycle(0, 0, 0, 8'd1, 1);
        #1;
        check("b_done_pulse", 32'(done_b), 32'd0);
        check("c_done_pulse", 32'(done_c), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
